// File: rtl/arith_pkg.sv
// Shared types for the arithmetic responder: request op-codes and FSM states.
package arith_pkg;

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;
  localparam logic [1:0] OPC_DIV = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_MUL = OPC_MUL,
    OP_DIV = OPC_DIV
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

endpackage

// File: rtl/arith_restoring_div.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
// Loaded by start, advanced one bit per step by the parent FSM.
module arith_restoring_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // quo_q starts as the dividend; its MSBs are consumed as quotient bits enter at the bottom
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/arith_responder.sv
// Sequential arithmetic responder: add/sub in one cycle, shift-add mul and restoring div over WIDTH cycles.
// Optional ARITH_DIVZERO_FLAG_EN adds rsp_div_by_zero and short-circuits divide-by-zero straight to DONE.
module arith_responder
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_carry,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic [WIDTH-1:0]   rsp_quotient,
`ifdef ARITH_DIVZERO_FLAG_EN
  output logic               rsp_div_by_zero,
`endif
  output logic [WIDTH-1:0]   rsp_remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                req_op_e;
  op_e                op_q;
  logic [CW-1:0]      step_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH:0]     add_res;
  logic               accept, div_step, last_step;
  logic [WIDTH-1:0]   div_dividend, div_quo, div_rem;
`ifdef ARITH_DIVZERO_FLAG_EN
  logic               div_skip;
  logic               dbz_q;
`endif

  assign req_op_e  = op_e'(req_op);
  assign last_step = (step_q == LAST_STEP);
`ifdef ARITH_DIVZERO_FLAG_EN
  assign div_skip  = (req_op_e == OP_DIV) && (req_b == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          case (req_op_e)
            OP_ADD, OP_SUB: state_d = S_ADD;
            OP_MUL:         state_d = S_MUL;
`ifdef ARITH_DIVZERO_FLAG_EN
            default:        state_d = div_skip ? S_DONE : S_DIV;
`else
            default:        state_d = S_DIV;
`endif
          endcase
        end
      end
      S_ADD: state_d = S_DONE;
      S_MUL: if (last_step) state_d = S_DONE;
      S_DIV: begin
        div_step = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1 so the carry doubles as the no-borrow flag
  always_comb begin
    if (op_q == OP_SUB) add_res = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    else                add_res = {1'b0, a_q} + {1'b0, b_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      step_q   <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= req_op_e;
        a_q      <= req_a;
        b_q      <= req_b;
        step_q   <= '0;
        sum_q    <= '0;
        carry_q  <= 1'b0;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, req_a};
        mplier_q <= req_b;
      end
      case (state_q)
        S_ADD: {carry_q, sum_q} <= add_res;
        S_MUL: begin
          step_q   <= step_q + CW'(1);
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
        S_DIV: step_q <= step_q + CW'(1);
        default: ;
      endcase
    end
  end

`ifdef ARITH_DIVZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dbz_q <= 1'b0;
    else if (accept) dbz_q <= div_skip;
  end
`endif

  // Non-div requests load zeros so the quotient/remainder fields read 0 for them
  assign div_dividend = (req_op_e == OP_DIV) ? req_a : '0;

  arith_restoring_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (req_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign rsp_sum     = sum_q;
  assign rsp_carry   = carry_q;
  assign rsp_product = acc_q;
`ifdef ARITH_DIVZERO_FLAG_EN
  assign rsp_quotient    = dbz_q ? '1 : div_quo;
  assign rsp_remainder   = dbz_q ? a_q : div_rem;
  assign rsp_div_by_zero = dbz_q && (state_q == S_DONE);
`else
  assign rsp_quotient  = div_quo;
  assign rsp_remainder = div_rem;
`endif

endmodule
